// File: rtl/grn_pkg.sv
// Shared GRN definitions: collector state encoding, default widths, pointer sizing.
package grn_pkg;

  localparam int unsigned GRN_DATA_WIDTH = 256;
  localparam int unsigned GRN_TASK_W     = 32;
  localparam int unsigned GRN_CNT_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } grn_state_e;

  // Width of an index into n ports; at least one bit.
  function automatic int unsigned grn_ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grn_result_collector_if.sv
// Core result ports and downstream write port of the GRN result collector.
interface grn_result_collector_if
  import grn_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned DATA_WIDTH = GRN_DATA_WIDTH
);

  logic [NUM_CORES-1:0]            core_valid;
  logic [NUM_CORES*DATA_WIDTH-1:0] core_data;
  logic [NUM_CORES-1:0]            core_last;
  logic [NUM_CORES-1:0]            core_ready;
  logic                            stall;
  logic                            wr_en;
  logic [DATA_WIDTH-1:0]           wr_data;
  logic [GRN_TASK_W-1:0]           task_done;
  logic [GRN_CNT_W-1:0]            cont_data;

  // Cores and the downstream FIFO controller together form the master side.
  modport master (
    output core_valid, core_data, core_last, stall,
    input  core_ready, wr_en, wr_data, task_done, cont_data
  );

  modport slave (
    input  core_valid, core_data, core_last, stall,
    output core_ready, wr_en, wr_data, task_done, cont_data
  );

endinterface

// File: rtl/grn_result_collector_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
  import grn_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = grn_ptr_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int unsigned cand;

  // Scan N candidates starting at ptr; the first asserted request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!any && req[PTR_W'(cand)]) begin
        any                 = 1'b1;
        grant[PTR_W'(cand)] = 1'b1;
        idx                 = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/grn_result_collector.sv
// Collects result words from NUM_CORES GRN cores round-robin into one write stream.
module grn_result_collector
  import grn_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned DATA_WIDTH = GRN_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  grn_result_collector_if.slave  bus
);

  localparam int unsigned      PTR_W    = grn_ptr_w(NUM_CORES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_CORES - 1);

  grn_state_e              state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                    wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [GRN_CNT_W-1:0]    cont_data_q, cont_data_d;
  logic [NUM_CORES-1:0]    task_done_q, task_done_d;

  logic [NUM_CORES-1:0]    req_c;
  logic [NUM_CORES-1:0]    grant_c;
  logic [PTR_W-1:0]        grant_idx_c;
  logic                    grant_any_c;
  logic                    xfer_c;
  logic [DATA_WIDTH-1:0]   sel_data_c;
  logic [GRN_TASK_W-1:0]   task_done_full_c;

  // Finished cores drop out of arbitration regardless of their valid.
  assign req_c = bus.core_valid & ~task_done_q;

  rr_arbiter #(
    .N     (NUM_CORES),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (req_c),
    .ptr   (rr_ptr_q),
    .grant (grant_c),
    .idx   (grant_idx_c),
    .any   (grant_any_c)
  );

  // A transfer needs RUN, start high, no back-pressure and a granted core.
  assign xfer_c         = (state_q == ST_RUN) && start && !bus.stall && grant_any_c;
  assign bus.core_ready = xfer_c ? grant_c : '0;

  // One-hot mux of the granted core's word.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (grant_c[i]) begin
        sel_data_c = sel_data_c | bus.core_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state, pointer, write strobe, counters and completion flags.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    cont_data_d = cont_data_q;
    task_done_d = task_done_q;

    if (xfer_c) begin
      wr_en_d     = 1'b1;
      wr_data_d   = sel_data_c;
      cont_data_d = cont_data_q + 32'd1;
      rr_ptr_d    = (grant_idx_c == LAST_IDX) ? '0 : grant_idx_c + PTR_W'(1);
      task_done_d = task_done_q | (grant_c & bus.core_last);
    end

    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (start && (&task_done_d)) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      cont_data_q <= '0;
      task_done_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      cont_data_q <= cont_data_d;
      task_done_q <= task_done_d;
    end
  end

  // Ports beyond NUM_CORES read as permanently finished.
  always_comb begin
    task_done_full_c                = '1;
    task_done_full_c[NUM_CORES-1:0] = task_done_q;
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.cont_data = cont_data_q;
  assign bus.task_done = task_done_full_c;

endmodule

// File: tb/tb_grn_result_collector.sv
// Randomized self-checking bench for grn_result_collector against a queue-free transfer model.
module tb_grn_result_collector;

  localparam int unsigned NC = 4;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic start;

  grn_result_collector_if #(.NUM_CORES(NC), .DATA_WIDTH(DW)) bus ();

  grn_result_collector #(.NUM_CORES(NC), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: collector phase (0 idle, 1 run, 2 done), next core to favour,
  // finished cores, words forwarded, and what the write port should show next.
  int          m_state;
  int          m_ptr;
  bit [NC-1:0] m_done;
  int unsigned m_cnt;
  bit          m_wr_en;
  logic [DW-1:0] m_wr_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_ptr     = 0;
    m_done    = '0;
    m_cnt     = 0;
    m_wr_en   = 1'b0;
    m_wr_data = '0;
  endtask

  // Core that should be served this cycle, or -1 when nothing may move.
  function automatic int model_pick();
    int c;
    if (m_state != 1 || !start || bus.stall) return -1;
    for (int off = 0; off < int'(NC); off++) begin
      c = (m_ptr + off) % NC;
      if (bus.core_valid[c] && !m_done[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive(input int valid_pct, input int last_pct, input int stall_pct, input int start_pct);
    for (int i = 0; i < int'(NC); i++) begin
      bus.core_valid[i] = ($urandom_range(99) < valid_pct);
      bus.core_last[i]  = ($urandom_range(99) < last_pct);
      bus.core_data[i*DW +: DW] = {$urandom, $urandom};
    end
    bus.stall = ($urandom_range(99) < stall_pct);
    start     = ($urandom_range(99) < start_pct);
  endtask

  // One clock: starts just after a falling edge and ends on the next one.
  task automatic step(input int valid_pct, input int last_pct, input int stall_pct, input int start_pct);
    int g;
    drive(valid_pct, last_pct, stall_pct, start_pct);
    #1;
    g = model_pick();
    chk("core_ready", 64'(bus.core_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    @(posedge clk);
    m_wr_en = 1'b0;
    if (g >= 0) begin
      m_wr_en   = 1'b1;
      m_wr_data = bus.core_data[g*DW +: DW];
      m_cnt     = m_cnt + 1;
      m_ptr     = (g + 1) % NC;
      if (bus.core_last[g]) m_done[g] = 1'b1;
    end
    if (start) begin
      if (m_state == 0) m_state = 1;
      else if (m_state == 1 && m_done == '1) m_state = 2;
    end
    #1;
    chk("wr_en", 64'(bus.wr_en), 64'(m_wr_en));
    if (m_wr_en) chk("wr_data", 64'(bus.wr_data), 64'(m_wr_data));
    chk("task_done", 64'(bus.task_done), 64'(32'hFFFF_FFF0 | 32'(m_done)));
    chk("cont_data", 64'(bus.cont_data), 64'(m_cnt));
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},     64'(bus.core_ready), 64'd0);
    chk({tag, "_wr_en"},     64'(bus.wr_en),      64'd0);
    chk({tag, "_wr_data"},   64'(bus.wr_data),    64'd0);
    chk({tag, "_cont_data"}, 64'(bus.cont_data),  64'd0);
    chk({tag, "_task_done"}, 64'(bus.task_done),  64'h0000_0000_FFFF_FFF0);
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b1;
    bus.core_valid = '1;
    bus.core_last  = '0;
    bus.core_data  = '0;
    bus.stall      = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // All cores streaming, no stall: pure rotation.
    for (int k = 0; k < 10; k++) step(100, 0, 0, 100);
    // Gap with start low: everything holds.
    for (int k = 0; k < 4; k++) step(100, 0, 0, 0);
    // Stall burst with all cores valid.
    for (int k = 0; k < 5; k++) step(100, 0, 100, 100);
    for (int k = 0; k < 6; k++) step(100, 0, 0, 100);
    // Mixed random traffic, no core finishing yet.
    for (int k = 0; k < 300; k++) step(60, 0, 20, 85);

    // Asynchronous reset in the middle of the run, clock low.
    #2;
    rst_n          = 1'b0;
    start          = 1'b1;
    bus.core_valid = '1;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with finishing cores until everyone is done.
    for (int k = 0; k < 3000 && m_state != 2; k++) step(70, 15, 15, 90);
    chk("reach_done", 64'(m_state), 64'd2);
    for (int k = 0; k < 50; k++) step(100, 50, 0, 100);
    chk("final_task_done", 64'(bus.task_done), 64'h0000_0000_FFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grn_result_collector.md
GRN_RESULT_COLLECTOR -- requirements
Module: grn_result_collector

Interface
REQ-001 Parameter NUM_CORES, default 4, number of GRN core result ports (1..32).
REQ-002 Parameter DATA_WIDTH, default 256, width of one result word.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  enable; the block holds its state while low.
REQ-006 core_valid  input  NUM_CORES  per-core result word valid.
REQ-007 core_data  input  NUM_CORES*DATA_WIDTH  per-core result word; core i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 core_last  input  NUM_CORES  qualifies core_valid; marks the core's final word.
REQ-009 core_ready  output  NUM_CORES  one-hot grant; a word transfers when core_valid[i] && core_ready[i].
REQ-010 stall  input  1  downstream back-pressure; driven from the output FIFO almost-full flag.
REQ-011 wr_en  output  1  one-cycle write strobe to the downstream FIFO-out controller.
REQ-012 wr_data  output  DATA_WIDTH  word accompanying wr_en.
REQ-013 task_done  output  32  bit i = core i finished; bits NUM_CORES..31 tied to 1.
REQ-014 cont_data  output  32  total words forwarded since reset.

Function
REQ-015 States: IDLE, RUN, DONE.
REQ-016 IDLE -> RUN on the first cycle start=1.
REQ-017 RUN -> DONE when all task_done bits are 1; DONE is absorbing until reset.
REQ-018 While start=0, the following hold: state, pointer, task_done and cont_data; core_ready=0; wr_en=0 on the next edge.
REQ-019 In RUN with start=1 and stall=0, grant exactly one valid core per cycle, round-robin from pointer rr_ptr.
REQ-020 Among valid cores, choose the first index >= rr_ptr, wrapping at NUM_CORES.
REQ-021 core_ready is combinational from rr_ptr, core_valid, state, start and stall.
REQ-022 A core whose task_done bit is set is never granted; its core_valid is ignored.
REQ-023 On a transfer from core g: rr_ptr <= (g+1) mod NUM_CORES, and the pointer wraps from NUM_CORES-1 to 0.
REQ-024 Without a transfer, rr_ptr is unchanged.
REQ-025 On a transfer, the next edge registers wr_en=1 and wr_data=core_data[g]; latency is exactly 1 cycle.
REQ-026 wr_en is 0 on every cycle without a transfer.
REQ-027 On a transfer, cont_data increments by 1; it is 32-bit and wraps modulo 2^32.
REQ-028 On a transfer with core_last[g]=1, task_done[g] is set on the same edge as wr_en.
REQ-029 stall=1 blocks all grants in that cycle (core_ready=0), and the register wr_en=0 on the next edge.
REQ-030 A word registered in the cycle before stall rose is still emitted.
REQ-031 DONE: core_ready=0, wr_en=0, task_done held all-ones.
REQ-032 The final word and its task_done bit appear on the same cycle, so downstream sees all-ones task_done no earlier than the last wr_en.

Reset
REQ-033 rst_n=0 asynchronously forces: state=IDLE, rr_ptr=0, wr_en=0, wr_data=0, cont_data=0, task_done[NUM_CORES-1:0]=0.
REQ-034 While rst_n=0, core_ready=0.
REQ-035 Reset mid-RUN discards any word being registered; no wr_en pulse follows deassertion until a new grant.
REQ-036 Reset release is synchronous to clk at the board level; no internal synchronizer.

Structure
REQ-037 The state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and default DATA_WIDTH live in the shared GRN package, grn_pkg.
REQ-038 A round-robin arbiter sub-module, rr_arbiter, takes (req, ptr) and returns (one-hot grant, encoded index, any) combinationally.
REQ-039 The collector instantiates rr_arbiter once with req = core_valid & ~task_done.

Verification
REQ-040 NUM_CORES=4, all valid every cycle, stall=0, 8 cycles -> grants 0,1,2,3,0,1,2,3; wr_en high 8 consecutive cycles starting 1 cycle later; cont_data=8.
REQ-041 Only core 2 valid, core_last=1 on its 3rd word -> 3 wr_en pulses; task_done=0xFFFFFFF4 after the 3rd pulse; core 2 never granted again.
REQ-042 stall=1 for cycles 5-9 with all cores valid -> core_ready=0 and no wr_en in cycles 6-10; rotation resumes at the next core in sequence.
REQ-043 rst_n pulsed low mid-RUN with rr_ptr=3, cont_data=17 -> all outputs zero immediately; after release, the first grant goes to core 0.
REQ-044 Each core sends 5 words and then last -> DONE after the 20th write; task_done=0xFFFFFFFF; no further wr_en for 50 cycles.
REQ-045 start deasserted for 4 cycles mid-stream -> no grants or writes during the gap; cont_data and rr_ptr unchanged across it.
